// File: rtl/edge_bbox_detect_pkg.sv
// rtl/edge_bbox_detect_pkg.sv - shared widths, types and FSM encodings for the edge bounding-box block
package edge_bbox_detect_pkg;

    localparam int COL_W = 11;
    localparam int ROW_W = 10;
    localparam int CNT_W = 21;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_LATCH  = 2'd2;

endpackage

// File: rtl/edge_bbox_acc.sv
// rtl/edge_bbox_acc.sv - pixel x/y counters plus running edge count and min/max box of the current frame
module edge_bbox_acc
    import edge_bbox_detect_pkg::*;
#(
    parameter col_t IMG_HDISP = 11'd1024,
    parameter row_t IMG_VDISP = 10'd720
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_acc_en,
    input  logic i_pix,
    input  logic i_bit,
    input  logic i_href,
    input  logic i_href_d,
    output col_t o_x,
    output row_t o_y,
    output cnt_t o_count,
    output col_t o_minx,
    output col_t o_maxx,
    output row_t o_miny,
    output row_t o_maxy
);

    col_t r_x;
    row_t r_y;
    cnt_t r_count;
    col_t r_minx;
    col_t r_maxx;
    row_t r_miny;
    row_t r_maxy;

    logic w_line_end;
    logic w_hit;

    assign w_line_end = i_href_d & ~i_href;
    // Pixels beyond the active window are counted past but never contribute to statistics.
    assign w_hit = i_acc_en & i_pix & i_bit & (r_x < IMG_HDISP) & (r_y < IMG_VDISP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_count <= '0;
            r_minx  <= '0;
            r_maxx  <= '0;
            r_miny  <= '0;
            r_maxy  <= '0;
        end else if (i_clear) begin
            r_x     <= '0;
            r_y     <= '0;
            r_count <= '0;
            r_minx  <= '1;
            r_maxx  <= '0;
            r_miny  <= '1;
            r_maxy  <= '0;
        end else begin
            if (w_line_end) begin
                r_x <= '0;
                if (r_y < IMG_VDISP)
                    r_y <= r_y + row_t'(1);
            end else if (i_pix && (r_x < IMG_HDISP)) begin
                r_x <= r_x + col_t'(1);
            end

            if (w_hit) begin
                if (r_count != CNT_MAX)
                    r_count <= r_count + cnt_t'(1);
                if (r_x < r_minx) r_minx <= r_x;
                if (r_x > r_maxx) r_maxx <= r_x;
                if (r_y < r_miny) r_miny <= r_y;
                if (r_y > r_maxy) r_maxy <= r_y;
            end
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_count = r_count;
    assign o_minx  = r_minx;
    assign o_maxx  = r_maxx;
    assign o_miny  = r_miny;
    assign o_maxy  = r_maxy;

endmodule

// File: rtl/edge_bbox_detect.sv
// rtl/edge_bbox_detect.sv - per-frame edge count and bounding box with one-clock video pass-through and box overlay
module edge_bbox_detect
    import edge_bbox_detect_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP    = 11'd1024,
    parameter logic [9:0]  IMG_VDISP    = 10'd720,
    parameter logic [20:0] EDGE_CNT_MIN = 21'd16,
    parameter logic        OVERLAY_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        per_img_Bit,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_Bit,
    output logic [10:0] box_left,
    output logic [10:0] box_right,
    output logic [9:0]  box_top,
    output logic [9:0]  box_bottom,
    output logic [20:0] edge_count,
    output logic        box_valid,
    output logic        frame_done
);

    logic [1:0] r_state;
    logic       r_vsync_d;
    logic       r_href_d;
    logic       r_start_pend;
    logic       r_post_vsync;
    logic       r_post_clken;
    logic       r_post_bit;
    col_t       r_box_left;
    col_t       r_box_right;
    row_t       r_box_top;
    row_t       r_box_bottom;
    cnt_t       r_edge_count;
    logic       r_box_valid;
    logic       r_frame_done;

    logic w_pix;
    logic w_vs_rise;
    logic w_vs_fall;
    logic w_start;
    logic w_valid;
    logic w_in_box;
    logic w_on_edge;
    logic w_border;
    col_t w_x;
    row_t w_y;
    cnt_t w_count;
    col_t w_minx;
    col_t w_maxx;
    row_t w_miny;
    row_t w_maxy;

    assign w_pix     = per_frame_href & per_frame_clken;
    assign w_vs_rise = per_frame_vsync & ~r_vsync_d;
    assign w_vs_fall = ~per_frame_vsync & r_vsync_d;
    // A rise seen during LATCH is remembered and started from IDLE on the next cycle.
    assign w_start   = (r_state == ST_IDLE) & per_frame_vsync & (w_vs_rise | r_start_pend);
    assign w_valid   = (w_count >= EDGE_CNT_MIN);

    edge_bbox_acc #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_start),
        .i_acc_en (r_state == ST_ACTIVE),
        .i_pix    (w_pix),
        .i_bit    (per_img_Bit),
        .i_href   (per_frame_href),
        .i_href_d (r_href_d),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_count  (w_count),
        .o_minx   (w_minx),
        .o_maxx   (w_maxx),
        .o_miny   (w_miny),
        .o_maxy   (w_maxy)
    );

    // Overlay is drawn from the box latched at the end of the previous frame.
    assign w_in_box  = (w_x >= r_box_left) & (w_x <= r_box_right) &
                       (w_y >= r_box_top)  & (w_y <= r_box_bottom);
    assign w_on_edge = (w_x == r_box_left) | (w_x == r_box_right) |
                       (w_y == r_box_top)  | (w_y == r_box_bottom);
    assign w_border  = OVERLAY_EN & r_box_valid & w_pix & w_in_box & w_on_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d    <= 1'b1;
            r_href_d     <= 1'b0;
            r_post_vsync <= 1'b0;
            r_post_clken <= 1'b0;
            r_post_bit   <= 1'b0;
        end else begin
            r_vsync_d    <= per_frame_vsync;
            r_href_d     <= per_frame_href;
            r_post_vsync <= per_frame_vsync;
            r_post_clken <= per_frame_clken;
            r_post_bit   <= per_frame_href & (per_img_Bit | w_border);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_start_pend <= 1'b0;
            r_frame_done <= 1'b0;
            r_edge_count <= '0;
            r_box_valid  <= 1'b0;
            r_box_left   <= '0;
            r_box_right  <= '0;
            r_box_top    <= '0;
            r_box_bottom <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state      <= ST_ACTIVE;
                        r_start_pend <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_vs_fall)
                        r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_state      <= ST_IDLE;
                    r_start_pend <= w_vs_rise;
                    r_frame_done <= 1'b1;
                    r_edge_count <= w_count;
                    r_box_valid  <= w_valid;
                    r_box_left   <= w_valid ? w_minx : '0;
                    r_box_right  <= w_valid ? w_maxx : '0;
                    r_box_top    <= w_valid ? w_miny : '0;
                    r_box_bottom <= w_valid ? w_maxy : '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign post_frame_vsync = r_post_vsync;
    assign post_frame_href  = r_href_d;
    assign post_frame_clken = r_post_clken;
    assign post_img_Bit     = r_post_bit;
    assign box_left         = r_box_left;
    assign box_right        = r_box_right;
    assign box_top          = r_box_top;
    assign box_bottom       = r_box_bottom;
    assign edge_count       = r_edge_count;
    assign box_valid        = r_box_valid;
    assign frame_done       = r_frame_done;

endmodule
